seg_scan_driver: RTL and testbench



---
 rtl/seg_pkg.sv | 27 ++
 rtl/seg_prescaler.sv | 41 ++++
 rtl/seg_scan_driver.sv | 100 ++++++++++
 tb/tb_seg_scan_driver.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants, digit-index type and digit-enable decode for the 7-segment scan driver.
package seg_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int SEG_W      = 7;

    localparam logic [SEG_W-1:0] SEG_OFF  = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_DASH = 7'b0000001;

    typedef logic [2:0] digit_idx_t;

    // Indices 6 and 7 are unreachable; they decode to no digit at all.
    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input digit_idx_t idx);
        logic [NUM_DIGITS-1:0] oh;
        case (idx)
            3'd0:    oh = 6'b000001;
            3'd1:    oh = 6'b000010;
            3'd2:    oh = 6'b000100;
            3'd3:    oh = 6'b001000;
            3'd4:    oh = 6'b010000;
            3'd5:    oh = 6'b100000;
            default: oh = 6'b000000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Digit-slot counter: tick on the last cycle of a slot; with GHOST_BLANK_EN, blank over the slot tail.
module seg_prescaler #(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
`ifdef GHOST_BLANK_EN
    ,
    output logic blank
`endif
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign tick = (cnt == LAST);

`ifdef GHOST_BLANK_EN
    // Compared at 32 bits so BLANK_CYCLES=0 (threshold == PRESCALE) never wraps into range.
    localparam logic [31:0] BLANK_FROM = 32'(PRESCALE - BLANK_CYCLES);
    assign blank = ({{(32-CW){1'b0}}, cnt} >= BLANK_FROM);
`endif

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed 7-segment driver with per-frame snapshot of the digit patterns.
// Optional anti-ghosting dead time at the tail of each slot: define GHOST_BLANK_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int PRESCALE       = 50000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEG_W-1:0]      d0,
    input  logic [SEG_W-1:0]      d1,
    input  logic [SEG_W-1:0]      d2,
    input  logic [SEG_W-1:0]      d3,
    input  logic [SEG_W-1:0]      d4,
    input  logic [SEG_W-1:0]      d5,
    output logic [SEG_W-1:0]      seg,
    output logic [NUM_DIGITS-1:0] dig,
    output logic                  frame
);

    localparam logic [SEG_W-1:0]      SEG_POL     = {SEG_W{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_POL     = {NUM_DIGITS{DIG_ACTIVE_LOW}};
    localparam logic [SEG_W-1:0]      SEG_OFF_LVL = SEG_OFF ^ SEG_POL;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF_LVL = DIG_POL;
    localparam digit_idx_t            LAST_IDX    = 3'(NUM_DIGITS - 1);

    digit_idx_t       idx;
    logic [SEG_W-1:0] snap [NUM_DIGITS];
    logic [SEG_W-1:0] din  [NUM_DIGITS];
    logic             primed;
    logic             tick;
    logic             blank;

    assign din[0] = d0;
    assign din[1] = d1;
    assign din[2] = d2;
    assign din[3] = d3;
    assign din[4] = d4;
    assign din[5] = d5;

    seg_prescaler #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (primed),
        .tick  (tick)
`ifdef GHOST_BLANK_EN
        ,
        .blank (blank)
`endif
    );

`ifndef GHOST_BLANK_EN
    assign blank = 1'b0;
`endif

    // Outputs are driven from the pre-edge idx/snap/cnt, giving a uniform one-cycle lag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            snap   <= '{default: '0};
            primed <= 1'b0;
            frame  <= 1'b0;
            seg    <= SEG_OFF_LVL;
            dig    <= DIG_OFF_LVL;
        end else begin
            frame <= 1'b0;
            if (!primed) begin
                snap   <= din;
                primed <= 1'b1;
                frame  <= 1'b1;
                seg    <= SEG_OFF_LVL;
                dig    <= DIG_OFF_LVL;
            end else begin
                if (blank) begin
                    seg <= SEG_OFF_LVL;
                    dig <= DIG_OFF_LVL;
                end else begin
                    seg <= snap[idx] ^ SEG_POL;
                    dig <= digit_onehot(idx) ^ DIG_POL;
                end
                if (tick) begin
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        snap  <= din;
                        frame <= 1'b1;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: three configurations driven in parallel and checked against a
// cycle-count model of the scan sequence. Honours GHOST_BLANK_EN when defined.
module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] d [6];

    logic [6:0] seg_o   [3];
    logic [5:0] dig_o   [3];
    logic       frame_o [3];

    int p_tab   [3] = '{4, 1, 4};
    int b_tab   [3] = '{1, 0, 1};
    bit sal_tab [3] = '{1'b0, 1'b0, 1'b1};
    bit dal_tab [3] = '{1'b1, 1'b1, 1'b0};

    logic [6:0] msnap     [3][6];
    logic [6:0] exp_seg   [3];
    logic [5:0] exp_dig   [3];
    logic       exp_frame [3];

    int k;
    int checks   = 0;
    int failures = 0;
    bit stim_en  = 1'b0;
    bit ghost;

    always #5 clk = ~clk;

    seg_scan_driver #(.PRESCALE(4), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst(rst), .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]), .d4(d[4]), .d5(d[5]),
        .seg(seg_o[0]), .dig(dig_o[0]), .frame(frame_o[0]));

    seg_scan_driver #(.PRESCALE(1), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst(rst), .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]), .d4(d[4]), .d5(d[5]),
        .seg(seg_o[1]), .dig(dig_o[1]), .frame(frame_o[1]));

    seg_scan_driver #(.PRESCALE(4), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b0)) dut_c (
        .clk(clk), .rst(rst), .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]), .d4(d[4]), .d5(d[5]),
        .seg(seg_o[2]), .dig(dig_o[2]), .frame(frame_o[2]));

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // k counts edges since reset release (k=0 loads the first snapshot). Outputs after edge k
    // show scan position (k-1) mod 6P of the snapshot taken at the latest multiple of 6P.
    task automatic predict();
        for (int i = 0; i < 3; i++) begin
            int         per;
            int         pos;
            int         slot;
            int         sub;
            bit         dark;
            logic [6:0] s_off;
            logic [5:0] d_off;
            per   = 6 * p_tab[i];
            s_off = sal_tab[i] ? 7'h7F : 7'h00;
            d_off = dal_tab[i] ? 6'h3F : 6'h00;
            if (k == 0) begin
                exp_seg[i]   = s_off;
                exp_dig[i]   = d_off;
                exp_frame[i] = 1'b1;
            end else begin
                pos  = (k - 1) % per;
                slot = pos / p_tab[i];
                sub  = pos % p_tab[i];
                dark = ghost && (sub >= p_tab[i] - b_tab[i]);
                exp_seg[i]   = dark ? s_off : (msnap[i][slot] ^ s_off);
                exp_dig[i]   = dark ? d_off : (6'(1 << slot) ^ d_off);
                exp_frame[i] = ((k % per) == 0);
            end
            if ((k % per) == 0) begin
                for (int j = 0; j < 6; j++) msnap[i][j] = d[j];
            end
        end
    endtask

    task automatic compareAll();
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("seg%0d_k%0d", i, k), 32'(seg_o[i]), 32'(exp_seg[i]));
            checkOutput($sformatf("dig%0d_k%0d", i, k), 32'(dig_o[i]), 32'(exp_dig[i]));
            checkOutput($sformatf("frame%0d_k%0d", i, k), 32'(frame_o[i]), 32'(exp_frame[i]));
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("%s_seg%0d", tag, i), 32'(seg_o[i]), sal_tab[i] ? 32'h7F : 32'h00);
            checkOutput($sformatf("%s_dig%0d", tag, i), 32'(dig_o[i]), dal_tab[i] ? 32'h3F : 32'h00);
            checkOutput($sformatf("%s_frame%0d", tag, i), 32'(frame_o[i]), 32'h0);
        end
    endtask

    task automatic applyStimulus();
        if (stim_en && ($urandom_range(3) == 0)) begin
            d[$urandom_range(5)] = 7'($urandom);
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            k++;
            predict();
            @(negedge clk);
            compareAll();
            applyStimulus();
        end
    endtask

    initial begin
`ifdef GHOST_BLANK_EN
        ghost = 1'b1;
`else
        ghost = 1'b0;
`endif
        rst  = 1'b1;
        d[0] = 7'b1111110;
        d[1] = 7'b0110000;
        d[2] = 7'b1101101;
        d[3] = 7'b1111001;
        d[4] = 7'b0110011;
        d[5] = 7'b1011011;
        #1;
        checkResetOutputs("rst_init");
        repeat (2) @(negedge clk);
        checkResetOutputs("rst_hold");

        rst = 1'b0;
        k   = -1;
        runCycles(30);

        // Frame in progress: a new d2 must only appear after the next snapshot.
        d[2] = 7'b1111111;
        runCycles(30);

        stim_en = 1'b1;
        runCycles(200);

        // Land mid-slot on digit 3 of the PRESCALE=4 instance, then reset asynchronously.
        for (int n = 0; n < 30; n++) begin
            if ((((k - 1) % 24) / 4 == 3) && (((k - 1) % 4) == 1)) break;
            runCycles(1);
        end
        checkOutput("reach_idx3", 32'((((k - 1) % 24) / 4)), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs("rst_async");
        repeat (2) @(negedge clk);
        checkResetOutputs("rst_mid");

        rst = 1'b0;
        k   = -1;
        runCycles(150);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
